// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract: the carry chain is cut into CHUNK-bit ripple
// slices, one slice per stage, with a single global stall driven by the output side.
module pipelined_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int NP     = (STAGES > 1) ? STAGES - 1 : 1;

    // Handshake: a transfer happens on an edge where valid && ready. out_valid/S/Cout/ovf
    // hold while out_valid && !out_ready; in_ready never depends on in_valid.
    logic                         en;

    logic [STAGES-1:0]            valid_q, valid_d;
    logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
    logic [STAGES-1:0]            carry_q, carry_d;
    logic [NP-1:0][WIDTH-1:0]     a_q, b_q;
    logic                         cmsb_q, cmsb_d;

    logic [STAGES-1:0][WIDTH-1:0] stg_a, stg_b, stg_s;
    logic [STAGES-1:0]            stg_c, stg_v;

    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    // Stage 0 sees the raw operands with subtract folded into B and the carry-in.
    assign stg_a[0] = A;
    assign stg_b[0] = B ^ {WIDTH{sub}};
    assign stg_s[0] = '0;
    assign stg_c[0] = C_in ^ sub;
    assign stg_v[0] = in_valid;

    for (genvar k = 1; k < STAGES; k++) begin : g_link
        assign stg_a[k] = a_q[k-1];
        assign stg_b[k] = b_q[k-1];
        assign stg_s[k] = sum_q[k-1];
        assign stg_c[k] = carry_q[k-1];
        assign stg_v[k] = valid_q[k-1];
    end

    always_comb begin
        logic             c;
        logic [WIDTH-1:0] s;
        valid_d = stg_v;
        sum_d   = '0;
        carry_d = '0;
        cmsb_d  = 1'b0;
        c       = 1'b0;
        s       = '0;
        for (int k = 0; k < STAGES; k++) begin
            c = stg_c[k];
            s = stg_s[k];
            for (int j = 0; j < CHUNK; j++) begin
                // The final stage keeps the carry into bit WIDTH-1 for overflow detection.
                if (k == STAGES - 1 && j == CHUNK - 1) begin
                    cmsb_d = c;
                end
                s[k*CHUNK+j] = stg_a[k][k*CHUNK+j] ^ stg_b[k][k*CHUNK+j] ^ c;
                c = (stg_a[k][k*CHUNK+j] & stg_b[k][k*CHUNK+j]) |
                    (c & (stg_a[k][k*CHUNK+j] ^ stg_b[k][k*CHUNK+j]));
            end
            sum_d[k]   = s;
            carry_d[k] = c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cmsb_q  <= 1'b0;
        end else if (en) begin
            valid_q <= valid_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            for (int k = 0; k < STAGES - 1; k++) begin
                a_q[k] <= stg_a[k];
                b_q[k] <= stg_b[k];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign S         = sum_q[STAGES-1];
    assign Cout      = carry_q[STAGES-1];
    assign ovf       = carry_q[STAGES-1] ^ cmsb_q;

endmodule
